// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, WIDTH steps per addition.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Busy,
    output logic             Done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, part;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c, last;

    assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE:  if (Start) state_nxt = SHIFT;
            SHIFT: begin
                Busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sum/Cout only move on the final shift edge so an aborted add never leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            part  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    a_sr  <= A;
                    b_sr  <= B;
                    carry <= Cin;
                    cnt   <= '0;
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    part  <= {fa_s, part[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        Sum  <= {fa_s, part[WIDTH-1:1]};
                        Cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last step, carry holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst)                     Overflow <= 1'b0;
        else if (state == SHIFT && last) Overflow <= carry ^ fa_c;
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, Start, Cin;
    logic [W-1:0] A, B, Sum;
    logic         Cout, Busy, Done;
`ifdef SERIAL_ADDER_OVF_EN
    logic         Overflow;
`endif

    int tests = 0;
    int fails = 0;
    logic [W:0] last_res;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Cin(Cin),
        .Sum(Sum), .Cout(Cout), .Busy(Busy), .Done(Done)
`ifdef SERIAL_ADDER_OVF_EN
        , .Overflow(Overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(logic [W-1:0] a, logic [W-1:0] b, logic c);
        int unsigned t;
        t = int'(a) + int'(b) + int'(c);
        return t[W:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Done) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1; Start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1;
        tick(); tick();
        tests++;
        if ({Sum, Cout, Busy, Done} !== '0) begin
            fails++;
            $display("FAIL reset_state: Sum=%h Cout=%b Busy=%b Done=%b, want all 0", Sum, Cout, Busy, Done);
        end
        // Start in the very first cycle after reset release must be taken.
        rst = 1'b0; A = 8'h12; B = 8'h34; Cin = 1'b0;
        tick();
        Start = 1'b0;
        tests++;
        if (Busy !== 1'b1) begin
            fails++;
            $display("FAIL start_after_reset: Busy=%b want 1", Busy);
        end
        wait_done(ok);
        tests++;
        if (!ok || {Cout, Sum} !== ref_add(8'h12, 8'h34, 1'b0)) begin
            fails++;
            $display("FAIL start_after_reset_sum: done=%b got %h want %h", ok, {Cout, Sum}, ref_add(8'h12, 8'h34, 1'b0));
        end
        last_res = ref_add(8'h12, 8'h34, 1'b0);
        tick();
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [W-1:0] vb [3] = '{8'h33, 8'h01, 8'hFF};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W:0]   exp;
        for (int v = 0; v < 3; v++) begin
            exp = ref_add(va[v], vb[v], vc[v]);
            A = va[v]; B = vb[v]; Cin = vc[v]; Start = 1'b1;
            tick();
            Start = 1'b0; A = '1; B = '1; Cin = 1'b1;
            for (int i = 0; i < W; i++) begin
                tests++;
                if (Busy !== 1'b1 || Done !== 1'b0 || {Cout, Sum} !== last_res) begin
                    fails++;
                    $display("FAIL vec%0d_busy_cyc%0d: Busy=%b Done=%b res=%h, want 1/0/%h", v, i, Busy, Done, {Cout, Sum}, last_res);
                end
                tick();
            end
            tests++;
            if (Done !== 1'b1 || Busy !== 1'b0 || {Cout, Sum} !== exp) begin
                fails++;
                $display("FAIL vec%0d_done: Done=%b Busy=%b res=%h, want 1/0/%h", v, Done, Busy, {Cout, Sum}, exp);
            end
            tick();
            tests++;
            if (Done !== 1'b0 || Busy !== 1'b0 || {Cout, Sum} !== exp) begin
                fails++;
                $display("FAIL vec%0d_after: Done=%b Busy=%b res=%h, want 0/0/%h", v, Done, Busy, {Cout, Sum}, exp);
            end
            last_res = exp;
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [W-1:0] a, b;
        logic c;
        logic [W:0] exp;
        for (int n = 0; n < 25; n++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            exp = ref_add(a, b, c);
            A = a; B = b; Cin = c; Start = 1'b1;
            tick();
            // Start and operand noise while shifting must be ignored.
            for (int i = 0; i < 3; i++) begin
                Start = 1'($urandom); A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
                tick();
            end
            Start = 1'b0;
            wait_done(ok);
            tests++;
            if (!ok || Busy !== 1'b0 || {Cout, Sum} !== exp) begin
                fails++;
                $display("FAIL random%0d: done=%b res=%h want %h (%h+%h+%b)", n, ok, {Cout, Sum}, exp, a, b, c);
            end
            last_res = exp;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp_q [$];
        logic [W:0] exp;
        logic [W:0] expect_res;
        bit         want_done;
        logic [W-1:0] a, b;
        logic c;
        Start = 1'b1;
        for (int n = 0; n < 30; n++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            A = a; B = b; Cin = c;
            // Accepts land every W+2 edges starting from this one.
            if (n % (W + 2) == 0) exp_q.push_back(ref_add(a, b, c));
            tick();
            want_done = (n % (W + 2) == W);
            tests++;
            if (Done !== want_done || (Busy && Done)) begin
                fails++;
                $display("FAIL b2b_done_edge%0d: Done=%b Busy=%b want Done=%b", n, Done, Busy, want_done);
            end
            if (want_done) begin
                exp = exp_q.pop_front();
                tests++;
                if ({Cout, Sum} !== exp) begin
                    fails++;
                    $display("FAIL b2b_result_edge%0d: res=%h want %h", n, {Cout, Sum}, exp);
                end
                last_res = exp;
            end
        end
        Start = 1'b0;
        expect_res = last_res;
        tick(); tick();
        tests++;
        if (Busy !== 1'b0 || {Cout, Sum} !== expect_res) begin
            fails++;
            $display("FAIL b2b_idle: Busy=%b res=%h want 0/%h", Busy, {Cout, Sum}, expect_res);
        end
    endtask

    task automatic test_abort();
        bit seen_done;
        bit ok;
        A = 8'h5A; B = 8'h33; Cin = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Sum !== '0 || Cout !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: Busy=%b Done=%b Sum=%h Cout=%b want 0/0/00/0", Busy, Done, Sum, Cout);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (Done || Busy) seen_done = 1'b1;
            tick();
        end
        tests++;
        if (seen_done || Sum !== '0) begin
            fails++;
            $display("FAIL abort_quiet: activity=%b Sum=%h want 0/00", seen_done, Sum);
        end
        A = 8'h01; B = 8'h02; Cin = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(ok);
        tests++;
        if (!ok || {Cout, Sum} !== ref_add(8'h01, 8'h02, 1'b0)) begin
            fails++;
            $display("FAIL abort_recover: done=%b res=%h want %h", ok, {Cout, Sum}, ref_add(8'h01, 8'h02, 1'b0));
        end
        tick();
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_overflow();
        bit ok;
        logic [W-1:0] va [4] = '{8'h7F, 8'h80, 8'h10, 8'hC0};
        logic [W-1:0] vb [4] = '{8'h01, 8'h80, 8'h20, 8'hF0};
        logic [W:0] exp;
        logic sov;
        for (int v = 0; v < 4; v++) begin
            exp = ref_add(va[v], vb[v], 1'b0);
            // Signed overflow: same-sign operands producing opposite-sign result.
            sov = (va[v][W-1] == vb[v][W-1]) && (exp[W-1] != va[v][W-1]);
            A = va[v]; B = vb[v]; Cin = 1'b0; Start = 1'b1;
            tick();
            Start = 1'b0;
            wait_done(ok);
            tests++;
            if (!ok || {Cout, Sum} !== exp || Overflow !== sov) begin
                fails++;
                $display("FAIL ovf%0d: res=%h ovf=%b want %h/%b", v, {Cout, Sum}, Overflow, exp, sov);
            end
            tick();
        end
    endtask
`endif

    initial begin
        rst = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        last_res = '0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_abort();
`ifdef SERIAL_ADDER_OVF_EN
        test_overflow();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
